truth_table_sweeper: RTL and testbench

//   Hardware sequencer for a 3-input combinational function F(x,y,z): on start it drives all
//   8 input vectors (000..111), waits a settle time per vector, samples F into an 8-bit

---
 rtl/sweep_pkg.sv | 15 +
 rtl/settle_counter.sv | 27 ++
 rtl/truth_table_sweeper.sv | 161 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweep self-test controller.
package sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } sweep_state_t;

    localparam int unsigned N_VEC          = 8;
    localparam int unsigned IDX_W          = 3;
    localparam logic [7:0]  GOLDEN_DEFAULT = 8'h54;

endpackage

// File: rtl/settle_counter.sv
// Down-counter that times how long each input vector is held before sampling.
module settle_counter #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Built-in self-test sequencer: sweeps all 8 vectors of F(x,y,z) and checks against GOLDEN.
// Optional first-failure capture is enabled by defining SWEEP_FAIL_CAPTURE_EN.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned         SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0]    GOLDEN        = GOLDEN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             f_in,
    output logic             x_out,
    output logic             y_out,
    output logic             z_out,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] result,
`ifdef SWEEP_FAIL_CAPTURE_EN
    output logic [IDX_W-1:0] fail_idx,
    output logic             fail_valid,
`endif
    output logic             pass
);

    localparam int unsigned       CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N_VEC - 1);

    sweep_state_t     r_state;
    sweep_state_t     w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_vec;
    logic [N_VEC-1:0] r_result;
    logic             r_pass;
    logic [N_VEC-1:0] w_final;
    logic             w_accept;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic             w_last;

    settle_counter #(
        .CNT_W (CNT_W)
    ) u_settle_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (CNT_LOAD),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    assign w_last   = (r_idx == IDX_LAST);
    assign w_accept = (r_state == ST_IDLE) && start && !abort;

    // Result including the bit being sampled now, so pass is valid in the done cycle.
    always_comb begin
        w_final        = r_result;
        w_final[r_idx] = f_in;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = ST_SETTLE;
                    w_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (w_zero) begin
                    w_next = ST_SAMPLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_SETTLE;
                    w_load = 1'b1;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if (abort) begin
            w_next = ST_IDLE;
            w_load = 1'b0;
            w_dec  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= '0;
            r_vec    <= '0;
            r_result <= '0;
            r_pass   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (abort) begin
                r_idx    <= '0;
                r_vec    <= '0;
                r_result <= '0;
                r_pass   <= 1'b0;
            end else if (w_accept) begin
                r_idx    <= '0;
                r_vec    <= '0;
                r_result <= '0;
                r_pass   <= 1'b0;
            end else if (r_state == ST_SAMPLE) begin
                r_result <= w_final;
                if (w_last) begin
                    r_vec  <= '0;
                    r_pass <= (w_final == GOLDEN);
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                    r_vec <= r_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [IDX_W-1:0] r_fail_idx;
    logic             r_fail_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_idx   <= '0;
            r_fail_valid <= 1'b0;
        end else if (abort || w_accept) begin
            r_fail_idx   <= '0;
            r_fail_valid <= 1'b0;
        end else if ((r_state == ST_SAMPLE) && !r_fail_valid && (f_in != GOLDEN[r_idx])) begin
            r_fail_idx   <= r_idx;
            r_fail_valid <= 1'b1;
        end
    end

    assign fail_idx   = r_fail_idx;
    assign fail_valid = r_fail_valid;
`endif

    assign x_out  = r_vec[2];
    assign y_out  = r_vec[1];
    assign z_out  = r_vec[0];
    assign busy   = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign done   = (r_state == ST_DONE);
    assign result = r_result;
    assign pass   = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Closed-loop bench: sweeper drives a behavioural F core; expectations queued at start, checked at done.
module tb_truth_table_sweeper;

    localparam logic [7:0] TB_GOLDEN = 8'h54;
    localparam int         LATENCY   = 8 * (2 + 1);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       core_stuck;
    logic       f_in;
    logic       x_out, y_out, z_out;
    logic       busy, done, pass;
    logic [7:0] result;
`ifdef SWEEP_FAIL_CAPTURE_EN
    logic [2:0] fail_idx;
    logic       fail_valid;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] res;
        logic       pss;
        int         done_n;
        logic [2:0] fidx;
        logic       fval;
    } exp_t;

    exp_t exp_q[$];

    assign f_in = core_stuck ? 1'b0 : (~z_out & (x_out | y_out));

    always #5 clk = ~clk;

    truth_table_sweeper #(
        .SETTLE_CYCLES (2),
        .GOLDEN        (8'h54)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .f_in       (f_in),
        .x_out      (x_out),
        .y_out      (y_out),
        .z_out      (z_out),
        .busy       (busy),
        .done       (done),
        .result     (result),
`ifdef SWEEP_FAIL_CAPTURE_EN
        .fail_idx   (fail_idx),
        .fail_valid (fail_valid),
`endif
        .pass       (pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input bit stuck);
        exp_t       e;
        logic [2:0] v;
        e.res    = '0;
        e.fidx   = '0;
        e.fval   = 1'b0;
        e.done_n = LATENCY;
        for (int i = 0; i < 8; i++) begin
            v = i[2:0];
            e.res[i] = stuck ? 1'b0 : (~v[0] & (v[2] | v[1]));
            if (!e.fval && (e.res[i] != TB_GOLDEN[i])) begin
                e.fval = 1'b1;
                e.fidx = v;
            end
        end
        e.pss = (e.res == TB_GOLDEN);
        return e;
    endfunction

    // Called 1 time unit after an edge; start is sampled at the next edge (edge 0).
    task automatic issue_start();
        start = 1'b1;
        exp_q.push_back(model(core_stuck));
        step();
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_xyz"}, 32'({x_out, y_out, z_out}), 32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    task automatic run_sweep(input string tag, input int restart_at, input bit check_vec);
        exp_t e;
        bit   seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            if (check_vec) begin
                check({tag, "_busy"}, 32'(busy), (n < LATENCY) ? 32'd1 : 32'd0);
                check({tag, "_xyz"}, 32'({x_out, y_out, z_out}), (n < LATENCY) ? 32'(n / 3) : 32'd0);
            end
            if (done) begin
                seen = 1'b1;
                check({tag, "_sb_pending"}, 32'(exp_q.size()), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check({tag, "_done_cycle"}, 32'(n), 32'(e.done_n));
                    check({tag, "_result"}, 32'(result), 32'(e.res));
                    check({tag, "_pass"}, 32'(pass), 32'(e.pss));
`ifdef SWEEP_FAIL_CAPTURE_EN
                    check({tag, "_fail_valid"}, 32'(fail_valid), 32'(e.fval));
                    if (e.fval) check({tag, "_fail_idx"}, 32'(fail_idx), 32'(e.fidx));
`endif
                    step();
                    check({tag, "_done_pulse"}, 32'(done), 32'd0);
                    check({tag, "_result_held"}, 32'(result), 32'(e.res));
                    check({tag, "_pass_held"}, 32'(pass), 32'(e.pss));
                end
            end else begin
                start = (n == restart_at) ? 1'b1 : 1'b0;
                step();
                n++;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done || busy) seen = 1'b1;
            step();
        end
        check({tag, "_quiet"}, 32'(seen), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        core_stuck = 1'b0;

        // Reset state, both during and after reset.
        #12;
        check_idle_zero("rst_active");
        rst_n = 1'b1;
        step();
        check_idle_zero("rst_released");

        // Correct core, with per-cycle vector and busy tracking.
        issue_start();
        run_sweep("good", -1, 1'b1);

        // Stuck-at-0 core.
        core_stuck = 1'b1;
        step();
        issue_start();
        run_sweep("stuck", -1, 1'b0);
        core_stuck = 1'b0;

        // Abort mid-sweep (sampled at edge 10), then a normal restart.
        step();
        issue_start();
        for (int i = 1; i < 10; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        void'(exp_q.pop_back());
        check_idle_zero("abort");
        watch_no_done("abort", 30);
        issue_start();
        run_sweep("after_abort", -1, 1'b0);

        // start re-pulsed while busy is ignored.
        step();
        issue_start();
        run_sweep("repulse", 4, 1'b1);

        // start and abort together in IDLE.
        step();
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        watch_no_done("start_abort", 30);

        // Asynchronous reset between edges mid-sweep, then a normal sweep.
        issue_start();
        for (int i = 0; i < 11; i++) step();
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check_idle_zero("async_rst");
        step();
        rst_n = 1'b1;
        step();
        issue_start();
        run_sweep("after_rst", -1, 1'b1);

        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
